// File: rtl/led_fade8.sv
// led_fade8: 8-channel LED fade/PWM driver behind the LED port latch.
// Ports: clk, rst (async high), led_in[7:0], fade_en -> led_out[7:0], busy.
module led_fade8 #(
  parameter int PRESCALE = 256,
  parameter int PWM_BITS = 8,
  parameter int STEP     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] led_in,
  input  logic       fade_en,
  output logic [7:0] led_out,
  output logic       busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] BMAX = '1;
  localparam logic [PWM_BITS:0] STEP_W = (PWM_BITS + 1)'(STEP);

  logic [PW-1:0]       r_pre;
  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] r_bri [8];
  logic [7:0]          r_led;

  logic                w_tick;
  logic                w_pend;
  logic [PWM_BITS-1:0] w_tgt [8];
  logic [PWM_BITS:0]   w_up  [8];
  logic [PWM_BITS-1:0] w_dn  [8];
  logic [7:0]          w_lo;
  logic [PWM_BITS-1:0] w_nxt [8];
  logic [7:0]          w_ne;

  assign w_tick = (r_pre == PRE_LAST);
  assign w_pend = w_tick && (r_cnt == BMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // Step arithmetic is one bit wider; the carry bit flags overflow
  // above BMAX, and w_lo flags a step that would go below zero.
  for (genvar g = 0; g < 8; g++) begin : g_ch
    assign w_tgt[g] = led_in[g] ? BMAX : '0;
    assign w_up[g]  = {1'b0, r_bri[g]} + STEP_W;
    assign w_dn[g]  = r_bri[g] - STEP_W[PWM_BITS-1:0];
    assign w_lo[g]  = {1'b0, r_bri[g]} < STEP_W;
    assign w_ne[g]  = (r_bri[g] != w_tgt[g]);
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_nxt[i] = r_bri[i];
      if (!fade_en) begin
        w_nxt[i] = w_tgt[i];
      end else if (w_pend) begin
        if (r_bri[i] < w_tgt[i])
          w_nxt[i] = w_up[i][PWM_BITS] ?
                     BMAX : w_up[i][PWM_BITS-1:0];
        else if (r_bri[i] > w_tgt[i])
          w_nxt[i] = w_lo[i] ? '0 : w_dn[i];
      end
    end
  end

  // On-phase sits at the start of each period; full scale is solid on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++)
        r_bri[i] <= '0;
      r_led <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        r_bri[i] <= w_nxt[i];
        r_led[i] <= (r_bri[i] == BMAX) || (r_bri[i] > r_cnt);
      end
    end
  end

  assign led_out = r_led;
  assign busy    = |w_ne;

endmodule

// File: tb/tb_led_fade8.sv
// tb_led_fade8: self-checking bench for led_fade8.
// PRESCALE=2, PWM_BITS=4 (32-clk period); STEP=4 main, STEP=15 second copy.
module tb_led_fade8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] led_in;
  logic       fade_en;
  logic [7:0] led_out;
  logic [7:0] led_out_s;
  logic       busy;
  logic       busy_s;

  always #5 clk = ~clk;

  led_fade8 #(.PRESCALE(2), .PWM_BITS(4), .STEP(4)) u_dut (
    .clk(clk), .rst(rst), .led_in(led_in), .fade_en(fade_en),
    .led_out(led_out), .busy(busy)
  );

  led_fade8 #(.PRESCALE(2), .PWM_BITS(4), .STEP(15)) u_sat (
    .clk(clk), .rst(rst), .led_in(led_in), .fade_en(fade_en),
    .led_out(led_out_s), .busy(busy_s)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] vin;
    int         busy_now;
  } dvec_t;

  typedef struct {
    int m;
    int s;
    int first;
  } win_t;

  dvec_t tbl [8];
  int    q_led [$];
  win_t  q_win [$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic edge1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] v, input logic fe);
    @(negedge clk);
    rst     = 1'b1;
    led_in  = v;
    fade_en = fe;
    edge1;
    rst = 1'b0;
  endtask

  task automatic window(input int n, output int cm, output int cs,
                        output int first, output int others);
    cm = 0;
    cs = 0;
    first = 0;
    others = 0;
    for (int i = 0; i < n; i++) begin
      edge1;
      if (i == 0)
        first = int'(led_out[0]);
      cm += int'(led_out[0]);
      cs += int'(led_out_s[0]);
      if ((led_out[7:1] | led_out_s[7:1]) != 7'd0)
        others = 1;
    end
  endtask

  initial begin
    int   cm, cs, fst, oth;
    win_t w;

    tbl[0] = '{8'hA5, 1};
    tbl[1] = '{8'hA5, 0};
    tbl[2] = '{8'h3C, 1};
    tbl[3] = '{8'hFF, 1};
    tbl[4] = '{8'hFF, 0};
    tbl[5] = '{8'h00, 1};
    tbl[6] = '{8'h81, 1};
    tbl[7] = '{8'h81, 0};

    rst = 1'b1;
    led_in = 8'h00;
    fade_en = 1'b0;
    #12;

    // Reset state, direct mode
    do_reset(8'h00, 1'b0);
    chk("rst_led", int'(led_out), 0);
    chk("rst_busy", int'(busy), 0);

    for (int k = 0; k < 8; k++) begin
      led_in = tbl[k].vin;
      q_led.push_back(int'(tbl[k].vin));
      #1;
      chk("dir_busy_drv", int'(busy), tbl[k].busy_now);
      chk("dir_busy_drv_s", int'(busy_s), tbl[k].busy_now);
      edge1;
      chk("dir_busy_1edge", int'(busy | busy_s), 0);
      if (k >= 1) begin
        int e;
        e = q_led.pop_front();
        chk("dir_led", int'(led_out), e);
        chk("dir_led_s", int'(led_out_s), e);
      end
    end
    edge1;
    begin
      int e;
      e = q_led.pop_front();
      chk("dir_led_last", int'(led_out), e);
    end

    // Asynchronous reset mid-run
    led_in = 8'hFF;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_led", int'(led_out), 0);
    chk("arst_led_s", int'(led_out_s), 0);
    chk("arst_busy_ff", int'(busy), 1);
    led_in = 8'h00;
    #1;
    chk("arst_busy_00", int'(busy | busy_s), 0);

    // Fade up; first step exactly 32 edges after release
    do_reset(8'h01, 1'b1);
    chk("up_busy0", int'(busy), 1);
    window(31, cm, cs, fst, oth);
    chk("up_pre_cnt", cm, 0);
    chk("up_pre_cnt_s", cs, 0);
    chk("up_busy31", int'(busy & busy_s), 1);
    window(1, cm, cs, fst, oth);
    chk("sat_up_busy", int'(busy_s), 0);
    chk("up_busy32", int'(busy), 1);
    q_win.push_back('{8, 32, 1});
    q_win.push_back('{16, 32, 1});
    q_win.push_back('{24, 32, 1});
    q_win.push_back('{32, 32, 1});
    for (int j = 0; j < 4; j++) begin
      window(32, cm, cs, fst, oth);
      w = q_win.pop_front();
      chk("up_duty", cm, w.m);
      chk("up_duty_s", cs, w.s);
      chk("up_phase", fst, w.first);
      chk("up_others", oth, 0);
      if (j == 1)
        chk("up_busy_mid", int'(busy), 1);
      if (j == 2)
        chk("up_busy_done", int'(busy), 0);
    end

    // Reversal from bri=8; saturating copy falls 15 -> 0
    do_reset(8'h01, 1'b1);
    window(32, cm, cs, fst, oth);
    window(32, cm, cs, fst, oth);
    chk("rev_pre_duty", cm, 8);
    led_in = 8'h00;
    #1;
    chk("rev_busy", int'(busy & busy_s), 1);
    q_win.push_back('{16, 32, 1});
    q_win.push_back('{8, 0, 1});
    q_win.push_back('{0, 0, 0});
    q_win.push_back('{0, 0, 0});
    for (int j = 0; j < 4; j++) begin
      window(32, cm, cs, fst, oth);
      w = q_win.pop_front();
      chk("rev_duty", cm, w.m);
      chk("rev_duty_s", cs, w.s);
      chk("rev_phase", fst, w.first);
      chk("rev_others", oth, 0);
      if (j == 0) begin
        chk("rev_busy1", int'(busy), 1);
        chk("sat_dn_busy", int'(busy_s), 0);
      end
      if (j == 1)
        chk("rev_busy2", int'(busy), 0);
    end

    // Mode switch at bri=4
    do_reset(8'h01, 1'b1);
    window(32, cm, cs, fst, oth);
    chk("ms_pre", cm, 0);
    fade_en = 1'b0;
    #1;
    chk("ms_busy_drv", int'(busy), 1);
    edge1;
    chk("ms_busy_1edge", int'(busy | busy_s), 0);
    window(40, cm, cs, fst, oth);
    chk("ms_solid", cm, 40);
    chk("ms_solid_s", cs, 40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
